// File: rtl/song_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : song_sequencer
// Description : Note source for the square-wave tone generator. Walks a fixed
//               64-entry note table at a selectable tempo. Play, pause and
//               stop are controlled by one-cycle pulses.
//               The tone generator sounds only while fullnote != 0 and
//               note_gate is high.
// Ports       : clk, rst         - clock, synchronous active-high reset
//               play_i           - pulse: start / pause / resume
//               stop_i           - pulse: return to IDLE (beats play_i)
//               tempo_sel[1:0]   - note length = BEAT_TICKS >> tempo_sel
//               loop_i           - (SEQ_LOOP_EN only) wrap at end of song
//               fullnote[7:0]    - registered note code, 0 = rest
//               note_gate        - high = sound, low = articulation gap
//               position[5:0]    - current table address
//               seq_state[1:0]   - 0 IDLE, 1 PLAY, 2 PAUSE, 3 DONE
//               song_done        - pulse when the last entry ends without loop
// Config      : `define SEQ_LOOP_EN adds the loop_i input port.
// Revision    : 1.0 - initial release
// ============================================================================
module song_sequencer #(
    parameter logic [31:0] BEAT_TICKS = 32'd25_000_000,
    parameter int          SONG_LEN   = 42
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       play_i,
    input  logic       stop_i,
`ifdef SEQ_LOOP_EN
    input  logic       loop_i,
`endif
    input  logic [1:0] tempo_sel,
    output logic [7:0] fullnote,
    output logic       note_gate,
    output logic [5:0] position,
    output logic [1:0] seq_state,
    output logic       song_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [5:0] C_LAST_POS = 6'(SONG_LEN - 1);
    localparam logic [6:0] C_SONG_LEN = 7'(SONG_LEN);

    state_t      r_state;
    logic [31:0] r_counter;
    logic [31:0] r_dur;

    logic [31:0] w_dur_raw;
    logic [31:0] w_dur_new;
    logic [31:0] w_gate_len;
    logic [7:0]  w_rom;
    logic [7:0]  w_table;
    logic        w_loop;

`ifdef SEQ_LOOP_EN
    assign w_loop = loop_i;
`else
    assign w_loop = 1'b0;
`endif

    // Duration for the next note; a zero result at small BEAT_TICKS is
    // clamped so the counter always has at least one cycle per note.
    assign w_dur_raw  = BEAT_TICKS >> tempo_sel;
    assign w_dur_new  = (w_dur_raw == 32'd0) ? 32'd1 : w_dur_raw;

    // Gap is dur/16 cycles at the end of each note; zero when dur < 16.
    assign w_gate_len = r_dur - (r_dur >> 4);

    always_comb begin
        w_rom = 8'd0;
        case (position)
            6'd0:  w_rom = 8'd26;  6'd1:  w_rom = 8'd26;  6'd2:  w_rom = 8'd30;
            6'd3:  w_rom = 8'd30;  6'd4:  w_rom = 8'd31;  6'd5:  w_rom = 8'd31;
            6'd6:  w_rom = 8'd30;  6'd7:  w_rom = 8'd29;  6'd8:  w_rom = 8'd29;
            6'd9:  w_rom = 8'd28;  6'd10: w_rom = 8'd28;  6'd11: w_rom = 8'd27;
            6'd12: w_rom = 8'd27;  6'd13: w_rom = 8'd26;  6'd14: w_rom = 8'd30;
            6'd15: w_rom = 8'd30;  6'd16: w_rom = 8'd29;  6'd17: w_rom = 8'd29;
            6'd18: w_rom = 8'd28;  6'd19: w_rom = 8'd28;  6'd20: w_rom = 8'd27;
            6'd21: w_rom = 8'd30;  6'd22: w_rom = 8'd30;  6'd23: w_rom = 8'd29;
            6'd24: w_rom = 8'd29;  6'd25: w_rom = 8'd28;  6'd26: w_rom = 8'd28;
            6'd27: w_rom = 8'd27;  6'd28: w_rom = 8'd26;  6'd29: w_rom = 8'd26;
            6'd30: w_rom = 8'd30;  6'd31: w_rom = 8'd30;  6'd32: w_rom = 8'd31;
            6'd33: w_rom = 8'd31;  6'd34: w_rom = 8'd30;  6'd35: w_rom = 8'd29;
            6'd36: w_rom = 8'd29;  6'd37: w_rom = 8'd28;  6'd38: w_rom = 8'd28;
            6'd39: w_rom = 8'd27;  6'd40: w_rom = 8'd27;  6'd41: w_rom = 8'd26;
            default: w_rom = 8'd0;
        endcase
    end

    // Entries past the configured song length always read as rest.
    assign w_table = ({1'b0, position} < C_SONG_LEN) ? w_rom : 8'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            position  <= 6'd0;
            r_counter <= 32'd0;
            r_dur     <= 32'd1;
            fullnote  <= 8'd0;
            note_gate <= 1'b0;
            song_done <= 1'b0;
        end else begin
            // Outputs follow the pre-edge state, so they lag state/position
            // by one clock.
            song_done <= 1'b0;
            fullnote  <= (r_state == S_PLAY) ? w_table : 8'd0;
            note_gate <= (r_state == S_PLAY) && (r_counter < w_gate_len);

            if (stop_i) begin
                r_state   <= S_IDLE;
                position  <= 6'd0;
                r_counter <= 32'd0;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (play_i) begin
                            r_state   <= S_PLAY;
                            position  <= 6'd0;
                            r_counter <= 32'd0;
                            r_dur     <= w_dur_new;
                        end
                    end
                    S_PLAY: begin
                        if (play_i) begin
                            r_state <= S_PAUSE;
                        end else if (r_counter == r_dur - 32'd1) begin
                            r_counter <= 32'd0;
                            r_dur     <= w_dur_new;
                            if (position == C_LAST_POS) begin
                                if (w_loop) begin
                                    position <= 6'd0;
                                end else begin
                                    r_state   <= S_DONE;
                                    song_done <= 1'b1;
                                end
                            end else begin
                                position <= position + 6'd1;
                            end
                        end else begin
                            r_counter <= r_counter + 32'd1;
                        end
                    end
                    S_PAUSE: begin
                        // Resume keeps the held counter and latched duration.
                        if (play_i) begin
                            r_state <= S_PLAY;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign seq_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_song_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_song_sequencer
// Description : Directed self-checking bench for song_sequencer with
//               BEAT_TICKS=32 and SONG_LEN=4 (table head 26,26,30,30).
//               Inputs change 1 time unit after a rising edge; outputs are
//               sampled at the same point. "Edge Ek" below is the k-th rising
//               edge after the play pulse is driven.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_song_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       play_i;
    logic       stop_i;
    logic [1:0] tempo_sel;
    logic [7:0] fullnote;
    logic       note_gate;
    logic [5:0] position;
    logic [1:0] seq_state;
    logic       song_done;
`ifdef SEQ_LOOP_EN
    logic       loop_i;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    song_sequencer #(
        .BEAT_TICKS (32'd32),
        .SONG_LEN   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .play_i    (play_i),
        .stop_i    (stop_i),
`ifdef SEQ_LOOP_EN
        .loop_i    (loop_i),
`endif
        .tempo_sel (tempo_sel),
        .fullnote  (fullnote),
        .note_gate (note_gate),
        .position  (position),
        .seq_state (seq_state),
        .song_done (song_done)
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic pulse_play();
        play_i = 1'b1;
        tick(1);
        play_i = 1'b0;
    endtask

    task automatic pulse_stop();
        stop_i = 1'b1;
        tick(1);
        stop_i = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        play_i    = 1'b0;
        stop_i    = 1'b0;
        tempo_sel = 2'd0;
`ifdef SEQ_LOOP_EN
        loop_i    = 1'b0;
`endif
        tick(2);
        rst = 1'b0;

        // Reset state
        check("rst_state", 32'(seq_state), 0);
        check("rst_pos",   32'(position),  0);
        check("rst_note",  32'(fullnote),  0);
        check("rst_gate",  32'(note_gate), 0);
        check("rst_done",  32'(song_done), 0);

        // Tempo 0: dur 32, gate high 30 / low 2
        pulse_play();                                  // E1
        check("t1_state_n1", 32'(seq_state), 1);
        check("t1_note_n1",  32'(fullnote),  0);
        tick(1);                                       // E2
        check("t1_note_n2",  32'(fullnote),  26);
        check("t1_gate_n2",  32'(note_gate), 1);
        check("t1_pos_n2",   32'(position),  0);
        tick(29);                                      // E31
        check("t1_gate_e31", 32'(note_gate), 1);
        tick(1);                                       // E32
        check("t1_gate_e32", 32'(note_gate), 0);
        tick(1);                                       // E33
        check("t1_gate_e33", 32'(note_gate), 0);
        check("t1_pos_e33",  32'(position),  1);
        tick(1);                                       // E34
        check("t1_gate_e34", 32'(note_gate), 1);
        tick(30);                                      // E64
        check("t1_pos_e64",  32'(position),  1);
        tick(1);                                       // E65
        check("t1_pos_e65",  32'(position),  2);
        tick(1);                                       // E66
        check("t1_note_e66", 32'(fullnote),  30);
        pulse_stop();
        check("stop_state", 32'(seq_state), 0);
        check("stop_pos",   32'(position),  0);
        tick(1);
        check("stop_note",  32'(fullnote),  0);
        check("stop_gate",  32'(note_gate), 0);

        // Tempo change mid-note: current note 32, next 16
        pulse_play();                                  // E1
        tick(10);                                      // E11
        tempo_sel = 2'd1;
        tick(21);                                      // E32
        check("t5_pos_e32", 32'(position), 0);
        tick(1);                                       // E33
        check("t5_pos_e33", 32'(position), 1);
        tick(15);                                      // E48
        check("t5_pos_e48", 32'(position), 1);
        tick(1);                                       // E49
        check("t5_pos_e49", 32'(position), 2);
        pulse_stop();
        tempo_sel = 2'd0;

        // Pause at counter=10, resume for the remaining 22 clocks
        pulse_play();                                  // E1
        tick(10);                                      // E11, counter=10
        pulse_play();                                  // E12 -> PAUSE
        check("t3_state_pause", 32'(seq_state), 2);
        tick(1);                                       // E13
        check("t3_note_pause",  32'(fullnote),  0);
        check("t3_gate_pause",  32'(note_gate), 0);
        tick(5);                                       // E18
        check("t3_pos_hold",    32'(position),  0);
        pulse_play();                                  // E19 -> PLAY
        check("t3_state_res",   32'(seq_state), 1);
        tick(1);                                       // E20
        check("t3_note_res",    32'(fullnote),  26);
        tick(20);                                      // E40
        check("t3_pos_e40",     32'(position),  0);
        tick(1);                                       // E41
        check("t3_pos_e41",     32'(position),  1);
        pulse_stop();

        // Simultaneous play and stop during PLAY
        tempo_sel = 2'd3;
        pulse_play();                                  // E1
        tick(5);                                       // E6
        check("t4_pos_before", 32'(position), 1);
        play_i = 1'b1;
        stop_i = 1'b1;
        tick(1);
        play_i = 1'b0;
        stop_i = 1'b0;
        check("t4_state", 32'(seq_state), 0);
        check("t4_pos",   32'(position),  0);
        tick(1);
        check("t4_note",  32'(fullnote),  0);

        // Tempo 3 (dur 4): full song, gate never drops, end in DONE
        pulse_play();                                  // E1
        for (int k = 2; k <= 16; k++) begin
            tick(1);                                   // E2..E16
            check("t2_gate", 32'(note_gate), 1);
            check("t2_done_low", 32'(song_done), 0);
        end
        check("t2_pos_e16",   32'(position),  3);
        check("t2_state_e16", 32'(seq_state), 1);
        tick(1);                                       // E17
        check("t2_state_done", 32'(seq_state), 3);
        check("t2_done_pulse", 32'(song_done), 1);
        tick(1);                                       // E18
        check("t2_done_clear", 32'(song_done), 0);
        check("t2_note_done",  32'(fullnote),  0);
        check("t2_gate_done",  32'(note_gate), 0);
        tick(3);
        check("t2_state_stay", 32'(seq_state), 3);
        pulse_play();
        check("t2_restart_state", 32'(seq_state), 1);
        check("t2_restart_pos",   32'(position),  0);
        tick(1);
        check("t2_restart_note",  32'(fullnote),  26);

        // Reset mid-song
        tick(5);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("mr_state", 32'(seq_state), 0);
        check("mr_pos",   32'(position),  0);
        check("mr_note",  32'(fullnote),  0);
        check("mr_gate",  32'(note_gate), 0);

`ifdef SEQ_LOOP_EN
        // Loop enabled: wrap 3->0 without song_done, then finish with loop off
        tempo_sel = 2'd3;
        loop_i    = 1'b1;
        pulse_play();                                  // E1
        tick(15);                                      // E16
        check("lp_pos_e16", 32'(position), 3);
        tick(1);                                       // E17
        check("lp_state_wrap", 32'(seq_state), 1);
        check("lp_pos_wrap",   32'(position),  0);
        check("lp_no_done",    32'(song_done), 0);
        loop_i = 1'b0;
        tick(16);                                      // E33
        check("lp_state_done", 32'(seq_state), 3);
        check("lp_done_pulse", 32'(song_done), 1);
        pulse_play();
        check("lp_restart_pos", 32'(position), 0);
        pulse_stop();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
